imem_loader: RTL and testbench
==============================

# imem_loader

Write-side companion to the byte-wide instruction memory (1024 x 8, little-endian word layout, synchronous read). Accepts 32-bit instruction words over a valid/ready stream and writes each word as four byte writes into consecutive memory addresses, lowest byte first. Places a program image in instruction memory before the pipeline is released from stall. The block is a small FSM with an address pointer and a word counter.

## Interface
- `ADDR_W`, default 10: byte-address width. Memory depth is 2^ADDR_W bytes.
- `CNT_W`, default 9: width of the word-count input. Maximum word count is 2^CNT_W - 1.
- `clk` input, 1: single clock. All state updates on the rising edge.
- `rst` input, 1: reset is synchronous and active-high.
- `start` input, 1: one-cycle request to begin a load. Sampled only in IDLE.
- `base_addr` input, ADDR_W: first byte address. Latched on an accepted `start`.
- `word_count` input, CNT_W: number of words to load. Latched on an accepted `start`.
- `in_valid` input, 1: `in_data` holds a word.
- `in_data` input, 32: instruction word.
- `in_ready` output, 1: block can take a word.
- `mem_we` output, 1: byte write strobe to instruction memory.
- `mem_addr` output, ADDR_W: byte address for the write.
- `mem_wdata` output, 8: byte to write.
- `busy` output, 1: high in every state except IDLE.
- `done` output, 1: one-cycle pulse when a load completes.
- `wrap_err` output, 1: sticky flag. Set when a write address wraps past 2^ADDR_W - 1. Cleared on the next accepted `start`.

## Operation
- States:
  - IDLE: waiting for `start`.
  - WAIT_WORD: `in_ready` = 1, waiting for an input word.
  - WRITE: emitting the four bytes of the captured word; sub-index `bidx` runs 0..3.
  - DONE: signals completion.
- IDLE transitions:
  - With `start` = 1, latch `ptr` <= `base_addr` and `remaining` <= `word_count`, and clear `wrap_err`.
  - If `word_count` = 0, go to DONE; otherwise go to WAIT_WORD.
- WAIT_WORD transitions:
  - A handshake occurs when `in_valid` and `in_ready` are both 1.
  - On a handshake, capture `in_data` into `word_q`, set `bidx` <= 0, and go to WRITE.
  - If there is no handshake, stay in WAIT_WORD with no limit.
- WRITE behaviour, each cycle:
  - `mem_we` = 1, `mem_addr` = `ptr`, `mem_wdata` = `word_q[8*bidx +: 8]`.
  - `ptr` <= `ptr` + 1, modulo 2^ADDR_W.
  - If `ptr` = all-ones at that write, set `wrap_err`.
- WRITE exit: after `bidx` = 3, `remaining` <= `remaining` - 1. Go to DONE if the new value is 0, otherwise go to WAIT_WORD.
- DONE: `done` = 1 for exactly one cycle, then go to IDLE.
- Byte order: byte k of the word lands at `base + 4*n + k`. Reading the word back through the instruction memory returns the original 32-bit value.
- Misaligned `base_addr` is legal and written as-is, with no alignment check.
- `start` while `busy` is ignored; no latching and no effect.
- `in_valid` outside WAIT_WORD is ignored because `in_ready` = 0; the source must hold the word until accepted.
- `rst` wins over everything in the same cycle.
  - State goes to IDLE.
  - `ptr`, `remaining`, `bidx`, `word_q` and `wrap_err` go to 0.
  - A reset mid-load aborts it. No further `mem_we` and no `done` pulse.

## Timing
- Reset values: `in_ready` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, `busy` = 0, `done` = 0, `wrap_err` = 0.
- All outputs are decoded from registered state only. There is no combinational path from any input to any output.
- Latencies:
  - `start` accepted at edge t: `busy` = 1 and `in_ready` = 1 from cycle t+1.
  - Handshake at edge t: `mem_we` = 1 for cycles t+1 .. t+4.
  - Last byte written in cycle t: `done` = 1 in cycle t+1, `busy` = 0 from t+2.
- Throughput: 5 cycles per word with a source that is always valid. A load of N words takes 5N + 2 cycles from `start` to `done` (inclusive of DONE).
- `word_count` = 0: `done` pulses 2 cycles after `start`, with no writes.

## Structure
- Shared package `imem_pkg` holds:
  - `BYTES_PER_WORD` = 4
  - `IMEM_ADDR_W` = 10
  - the `loader_state_t` enum (IDLE, WAIT_WORD, WRITE, DONE)
- The instruction memory imports the same `IMEM_ADDR_W`.
- Single module, no sub-modules. The byte-lane select is an inline mux on `bidx`.

## Test plan
- `base` = 0x000, `count` = 1, word 0x8C220004 → writes at addresses 0..3 of 0x04, 0x00, 0x22, 0x8C in 4 consecutive cycles; `done` 1 cycle later. A read-back through the instruction memory at PC 0 returns 0x8C220004.
- `base` = 0x010, `count` = 3, source stalls 3 cycles between words → 12 writes at 0x010..0x01B; `in_ready` is low during each WRITE burst; `done` pulses once.
- `count` = 0 → no `mem_we`; `done` pulses 2 cycles after `start`; `wrap_err` = 0.
- `base` = 0x3FE, `count` = 1, word 0xAABBCCDD → writes 0xDD@0x3FE, 0xCC@0x3FF, 0xBB@0x000, 0xAA@0x001; `wrap_err` = 1 and stays set until the next `start`.
- `rst` asserted on the second byte of word 2 of a 4-word load → all outputs 0 on the next cycle, no more writes, no `done`; a new `start` then loads normally.
- `start` pulsed while `busy` with a different `base_addr`/`word_count` → ignored; the original load completes with unchanged addresses.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory and its write-side loader.
package imem_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned IMEM_ADDR_W    = 10;
    localparam int unsigned BIDX_W         = $clog2(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        StIdle,
        StWaitWord,
        StWrite,
        StDone
    } loader_state_t;

endpackage

// File: rtl/imem_loader.sv
// Streams 32-bit words into the byte-wide instruction memory, four byte writes per word,
// lowest byte first, starting at a latched base address.
module imem_loader
    import imem_pkg::*;
#(
    parameter int unsigned ADDR_W = IMEM_ADDR_W,
    parameter int unsigned CNT_W  = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              wrap_err
);

    localparam logic [BIDX_W-1:0] LastBidx = BIDX_W'(BYTES_PER_WORD - 1);

    loader_state_t     state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic [BIDX_W-1:0] bidx_q, bidx_d;
    logic [31:0]       word_q, word_d;
    logic              wrap_err_q, wrap_err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            remaining_q <= '0;
            bidx_q      <= '0;
            word_q      <= '0;
            wrap_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
            bidx_q      <= bidx_d;
            word_q      <= word_d;
            wrap_err_q  <= wrap_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        bidx_d      = bidx_q;
        word_d      = word_q;
        wrap_err_d  = wrap_err_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    ptr_d       = base_addr;
                    remaining_d = word_count;
                    wrap_err_d  = 1'b0;
                    state_d     = (word_count == '0) ? StDone : StWaitWord;
                end
            end
            StWaitWord: begin
                if (in_valid && in_ready) begin
                    word_d  = in_data;
                    bidx_d  = '0;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                ptr_d  = ptr_q + ADDR_W'(1);
                bidx_d = bidx_q + BIDX_W'(1);
                // Writing the top address means the pointer rolls over to zero.
                if (ptr_q == '1) begin
                    wrap_err_d = 1'b1;
                end
                if (bidx_q == LastBidx) begin
                    remaining_d = remaining_q - CNT_W'(1);
                    state_d     = (remaining_q == CNT_W'(1)) ? StDone : StWaitWord;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            StIdle: begin
                busy = 1'b0;
            end
            StWaitWord: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            StWrite: begin
                mem_we    = 1'b1;
                mem_addr  = ptr_q;
                mem_wdata = word_q[{bidx_q, 3'b000} +: 8];
                busy      = 1'b1;
            end
            StDone: begin
                done = 1'b1;
                busy = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign wrap_err = wrap_err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed vector table, reset abort sequence and
// randomized loads checked against an address/byte/cycle model of the load.
module tb_imem_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [9:0] base_addr;
    logic [8:0] word_count;
    logic       in_valid;
    logic [31:0] in_data;
    logic       in_ready;
    logic       mem_we;
    logic [9:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       busy;
    logic       done;
    logic       wrap_err;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem_model [1024];

    typedef struct {
        int cyc;
        int addr;
        int data;
    } wrec_t;

    typedef struct {
        int          base;
        int          count;
        int          stall;
        bit          poke;
        logic [31:0] w0;
        bit          exp_wrap;
        int          exp_cyc;
    } vec_t;

    imem_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .wrap_err   (wrap_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Runs one load; the source holds each word off for `stall` cycles of in_ready.
    task automatic run_load(input int base, input int count, input int stall, input bit poke,
                            input logic [31:0] w0, input bit rnd, input bit exp_wrap,
                            input int exp_cyc, input string tag);
        logic [31:0] words[$];
        wrec_t       got[$];
        wrec_t       r;
        int          cyc, done_cyc, dones, idx, gap, bad_ready, bad_wr, stray, bad_rb;
        bit          hs;
        int          a, i;
        logic [31:0] rb;
        for (int n = 0; n < count; n++) begin
            words.push_back(rnd ? $urandom : w0 + n * 32'h0101_0101);
        end
        @(negedge clk);
        start      = 1'b1;
        base_addr  = 10'(base);
        word_count = 9'(count);
        @(negedge clk);
        start      = 1'b0;
        base_addr  = 10'($urandom);
        word_count = 9'($urandom);
        check({tag, ":wrap_clear"}, int'(wrap_err), 0);
        check({tag, ":busy_start"}, int'(busy), 1);
        cyc = 1; done_cyc = -1; dones = 0; idx = 0; gap = stall; hs = 1'b0; bad_ready = 0;
        forever begin
            if (mem_we) begin
                r.cyc = cyc; r.addr = int'(mem_addr); r.data = int'(mem_wdata);
                got.push_back(r);
                mem_model[mem_addr] = mem_wdata;
                if (in_ready) bad_ready++;
            end
            if (done) begin
                dones++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) break;
            if (cyc >= 400) break;
            if (hs) begin
                in_valid = 1'b0; idx++; gap = stall; hs = 1'b0;
            end
            if (!in_valid && idx < count) begin
                if (gap == 0) begin
                    in_valid = 1'b1;
                    in_data  = words[idx];
                end else if (in_ready) begin
                    gap--;
                end
            end
            hs = in_valid && in_ready;
            if (poke && cyc == 3) begin
                start = 1'b1; base_addr = 10'(base + 'h55); word_count = 9'(count + 2);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        in_valid = 1'b0;
        check({tag, ":done_seen"}, int'(done_cyc >= 0), 1);
        check({tag, ":cycles"}, done_cyc + 1, exp_cyc);
        check({tag, ":busy_after"}, int'(busy), 0);
        check({tag, ":write_count"}, got.size(), 4 * count);
        check({tag, ":ready_in_write"}, bad_ready, 0);
        bad_wr = 0;
        for (int n = 0; n < count; n++) begin
            for (int k = 0; k < 4; k++) begin
                i = 4 * n + k;
                if (i < got.size()) begin
                    if (got[i].addr != (base + 4 * n + k) % 1024 ||
                        got[i].data != int'((words[n] >> (8 * k)) & 32'hFF) ||
                        got[i].cyc != n * (5 + stall) + 2 + stall + k) begin
                        bad_wr++;
                    end
                end
            end
        end
        check({tag, ":write_seq"}, bad_wr, 0);
        bad_rb = 0;
        for (int n = 0; n < count; n++) begin
            for (int k = 0; k < 4; k++) begin
                a = (base + 4 * n + k) % 1024;
                rb[8*k +: 8] = mem_model[a];
            end
            if (rb !== words[n]) bad_rb++;
        end
        check({tag, ":readback"}, bad_rb, 0);
        check({tag, ":wrap"}, int'(wrap_err), int'(exp_wrap));
        stray = 0;
        repeat (3) begin
            @(negedge clk);
            if (mem_we || done || busy) stray++;
        end
        check({tag, ":idle_quiet"}, stray, 0);
        check({tag, ":wrap_sticky"}, int'(wrap_err), int'(exp_wrap));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        int   nw, stray, base, count, stall;
        bit   poke;

        rst = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
        in_valid = 1'b0; in_data = '0;
        for (int i = 0; i < 1024; i++) mem_model[i] = 8'h00;
        repeat (2) @(negedge clk);
        check("reset_outputs",
              int'({in_ready, mem_we, mem_addr, mem_wdata, busy, done, wrap_err}), 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_outputs", int'({in_ready, mem_we, busy, done, wrap_err}), 0);

        // base, count, stall, poke, first word, expected wrap, start-to-done cycles inclusive
        vecs[0] = '{'h000, 1, 0, 1'b0, 32'h8C22_0004, 1'b0, 7};
        vecs[1] = '{'h010, 3, 3, 1'b0, 32'h0000_0013, 1'b0, 26};
        vecs[2] = '{'h020, 0, 0, 1'b0, 32'h0000_0000, 1'b0, 2};
        vecs[3] = '{'h3FE, 1, 0, 1'b0, 32'hAABB_CCDD, 1'b1, 7};
        vecs[4] = '{'h040, 2, 0, 1'b1, 32'h1234_5678, 1'b0, 12};
        // Ending exactly on the top address still writes at all-ones, so the flag sets.
        vecs[5] = '{'h3F8, 2, 0, 1'b0, 32'hDEAD_BEEF, 1'b1, 12};
        vecs[6] = '{'h001, 2, 1, 1'b0, 32'h0BAD_F00D, 1'b0, 14};
        for (int v = 0; v < 7; v++) begin
            run_load(vecs[v].base, vecs[v].count, vecs[v].stall, vecs[v].poke, vecs[v].w0,
                     1'b0, vecs[v].exp_wrap, vecs[v].exp_cyc, $sformatf("vec%0d", v));
        end

        // Abort on the second byte of the second word of a 4-word load.
        @(negedge clk);
        start = 1'b1; base_addr = 10'h100; word_count = 9'd4;
        in_valid = 1'b1; in_data = 32'h1122_3344;
        @(negedge clk);
        start = 1'b0;
        nw = 0;
        for (int c = 0; c < 40; c++) begin
            if (mem_we) nw++;
            if (nw == 6) break;
            @(negedge clk);
        end
        check("rst:reached_byte", nw, 6);
        rst = 1'b1;
        @(negedge clk);
        check("rst:outputs_zero",
              int'({in_ready, mem_we, mem_addr, mem_wdata, busy, done, wrap_err}), 0);
        rst = 1'b0;
        in_valid = 1'b0;
        stray = 0;
        repeat (10) begin
            @(negedge clk);
            if (mem_we || done || busy) stray++;
        end
        check("rst:no_activity", stray, 0);
        run_load('h200, 2, 0, 1'b0, 32'hCAFE_0001, 1'b0, 1'b0, 12, "after_rst");

        for (int t = 0; t < 25; t++) begin
            base  = int'($urandom_range(0, 1023));
            count = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
            stall = int'($urandom_range(0, 3));
            poke  = 1'($urandom_range(0, 1));
            run_load(base, count, stall, poke, 32'h0, 1'b1,
                     (count > 0) && (base + 4 * count >= 1024),
                     (count == 0) ? 2 : (5 + stall) * count + 2, $sformatf("rnd%0d", t));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
